// File: rtl/butterphy_jtag_model.sv
// butterphy_jtag_model: behavioural IEEE 1149.1 JTAG slave of the PHY top with IDCODE, BYPASS, config and dump-status registers; define BUTTERPHY_TDO_NEGEDGE_EN to retime tdo on the falling tck edge
module butterphy_jtag_model #(
    parameter int          IR_WIDTH   = 5,
    parameter int          DR_WIDTH   = 32,
    parameter int          NUM_CFG    = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1BEEF0A5
) (
    input  logic                          jtag_intf_i_phy_tck,
    input  logic                          jtag_intf_i_phy_trst_n,
    input  logic                          jtag_intf_i_phy_tms,
    input  logic                          jtag_intf_i_phy_tdi,
    input  logic                          ext_dump_start,
    output logic                          jtag_intf_i_phy_tdo,
    output logic [NUM_CFG*DR_WIDTH-1:0]   cfg_out,
    output logic [3:0]                    tap_state
);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SH_DR    = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SH_IR    = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } state_t;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_STATUS = IR_WIDTH'(2 + NUM_CFG);

    state_t                             state, next_state;
    logic   [IR_WIDTH-1:0]              ir, ir_shift;
    logic   [DR_WIDTH-1:0]              dr_shift, cap_val;
    logic                               bypass, sel_bypass, tlr_entry;
    logic   [NUM_CFG-1:0][DR_WIDTH-1:0] cfg;
    logic   [15:0]                      dump_count;
    logic                               dump_active, dump_prev, dump_rise, tdo_comb;

    assign tap_state = state;
    assign cfg_out   = cfg;
    assign tlr_entry = (next_state == TLR) && (state != TLR);
    assign dump_rise = ext_dump_start && !dump_prev;

    // TAP state register
    always_ff @(posedge jtag_intf_i_phy_tck or negedge jtag_intf_i_phy_trst_n) begin
        if (!jtag_intf_i_phy_trst_n) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    // standard 1149.1 next-state function on tms
    always_comb begin
        next_state = state;
        unique case (state)
            TLR:      next_state = jtag_intf_i_phy_tms ? TLR    : RTI;
            RTI:      next_state = jtag_intf_i_phy_tms ? SEL_DR : RTI;
            SEL_DR:   next_state = jtag_intf_i_phy_tms ? SEL_IR : CAP_DR;
            CAP_DR:   next_state = jtag_intf_i_phy_tms ? EX1_DR : SH_DR;
            SH_DR:    next_state = jtag_intf_i_phy_tms ? EX1_DR : SH_DR;
            EX1_DR:   next_state = jtag_intf_i_phy_tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: next_state = jtag_intf_i_phy_tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   next_state = jtag_intf_i_phy_tms ? UPD_DR : SH_DR;
            UPD_DR:   next_state = jtag_intf_i_phy_tms ? SEL_DR : RTI;
            SEL_IR:   next_state = jtag_intf_i_phy_tms ? TLR    : CAP_IR;
            CAP_IR:   next_state = jtag_intf_i_phy_tms ? EX1_IR : SH_IR;
            SH_IR:    next_state = jtag_intf_i_phy_tms ? EX1_IR : SH_IR;
            EX1_IR:   next_state = jtag_intf_i_phy_tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: next_state = jtag_intf_i_phy_tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   next_state = jtag_intf_i_phy_tms ? UPD_IR : SH_IR;
            UPD_IR:   next_state = jtag_intf_i_phy_tms ? SEL_DR : RTI;
        endcase
    end

    // instruction decode and DR capture value; unknown codes fall through to BYPASS
    always_comb begin
        cap_val    = '0;
        sel_bypass = !((ir == IR_IDCODE) || (ir == IR_STATUS));
        if (ir == IR_IDCODE) cap_val = DR_WIDTH'(IDCODE_VAL);
        if (ir == IR_STATUS) cap_val = DR_WIDTH'({dump_count, 15'b0, dump_active});
        for (int k = 0; k < NUM_CFG; k++) begin
            if (ir == IR_WIDTH'(2 + k)) begin
                cap_val    = cfg[k];
                sel_bypass = 1'b0;
            end
        end
    end

    // IR shift path and instruction register; TLR entry falls back to IDCODE
    always_ff @(posedge jtag_intf_i_phy_tck or negedge jtag_intf_i_phy_trst_n) begin
        if (!jtag_intf_i_phy_trst_n) begin
            ir       <= IR_IDCODE;
            ir_shift <= '0;
        end else begin
            if (state == CAP_IR) ir_shift <= IR_WIDTH'(1);
            else if (state == SH_IR) ir_shift <= {jtag_intf_i_phy_tdi, ir_shift[IR_WIDTH-1:1]};
            if (tlr_entry) ir <= IR_IDCODE;
            else if (state == UPD_IR) ir <= ir_shift;
        end
    end

    // DR capture/shift and config register update
    always_ff @(posedge jtag_intf_i_phy_tck or negedge jtag_intf_i_phy_trst_n) begin
        if (!jtag_intf_i_phy_trst_n) begin
            dr_shift <= '0;
            bypass   <= 1'b0;
            cfg      <= '0;
        end else begin
            if (state == CAP_DR) begin
                dr_shift <= cap_val;
                bypass   <= 1'b0;
            end else if (state == SH_DR) begin
                if (sel_bypass) bypass <= jtag_intf_i_phy_tdi;
                else dr_shift <= {jtag_intf_i_phy_tdi, dr_shift[DR_WIDTH-1:1]};
            end
            for (int k = 0; k < NUM_CFG; k++) begin
                if (state == UPD_DR && ir == IR_WIDTH'(2 + k)) cfg[k] <= dr_shift;
            end
        end
    end

    // dump request edge detect; a rise beats a simultaneous TLR-entry clear
    always_ff @(posedge jtag_intf_i_phy_tck or negedge jtag_intf_i_phy_trst_n) begin
        if (!jtag_intf_i_phy_trst_n) begin
            dump_prev   <= 1'b0;
            dump_active <= 1'b0;
            dump_count  <= '0;
        end else begin
            dump_prev <= ext_dump_start;
            if (dump_rise) begin
                dump_active <= 1'b1;
                if (dump_count != 16'hFFFF) dump_count <= dump_count + 16'd1;
            end else if (tlr_entry) begin
                dump_active <= 1'b0;
            end
        end
    end

    assign tdo_comb = (state == SH_DR) ? (sel_bypass ? bypass : dr_shift[0]) :
                      (state == SH_IR) ? ir_shift[0] : 1'b0;

`ifdef BUTTERPHY_TDO_NEGEDGE_EN
    logic tdo_q;

    // retime tdo half a cycle later so it is stable around the next rising edge
    always_ff @(negedge jtag_intf_i_phy_tck or negedge jtag_intf_i_phy_trst_n) begin
        if (!jtag_intf_i_phy_trst_n) begin
            tdo_q <= 1'b0;
        end else begin
            tdo_q <= tdo_comb;
        end
    end

    assign jtag_intf_i_phy_tdo = tdo_q;
`else
    assign jtag_intf_i_phy_tdo = tdo_comb;
`endif

endmodule

// File: tb/tb_butterphy_jtag_model.sv
// tb_butterphy_jtag_model: directed and randomized JTAG scans against a queue-based reference model
module tb_butterphy_jtag_model;

    localparam int IRW = 5;
    localparam int DRW = 32;
    localparam int NC  = 4;
    localparam int CW  = NC * DRW;

    logic          tck = 1'b0, trst_n = 1'b0, tms = 1'b1, tdi = 1'b0, dump = 1'b0;
    logic          tdo;
    logic [CW-1:0] cfg_out;
    logic [3:0]    tap_state;

    int checks = 0, failures = 0;
    bit started = 1'b0;
    bit dmp = 1'b0;

    butterphy_jtag_model #(
        .IR_WIDTH(IRW), .DR_WIDTH(DRW), .NUM_CFG(NC), .IDCODE_VAL(32'h1BEEF0A5)
    ) dut (
        .jtag_intf_i_phy_tck(tck),
        .jtag_intf_i_phy_trst_n(trst_n),
        .jtag_intf_i_phy_tms(tms),
        .jtag_intf_i_phy_tdi(tdi),
        .ext_dump_start(dump),
        .jtag_intf_i_phy_tdo(tdo),
        .cfg_out(cfg_out),
        .tap_state(tap_state)
    );

    always #5 tck = ~tck;

    // reference model: state transition table plus queues holding the active shift paths
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int            m_state, m_ir, m_count, m_ns;
    bit            m_active, m_prev, m_rise;
    bit            dq[$];
    bit            iq[$];
    logic [DRW-1:0] m_cfg [NC];
    logic [DRW-1:0] m_cap;
    logic [CW-1:0]  exp_cfg;
    bit             exp_tdo;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model update on each rising tck, reset asynchronously like the TAP
    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            m_state = 0; m_ir = 1; m_count = 0; m_active = 0; m_prev = 0;
            dq.delete(); iq.delete();
            foreach (m_cfg[k]) m_cfg[k] = '0;
        end else begin
            m_rise = dump && !m_prev;
            m_prev = dump;
            m_ns = tms ? nxt1[m_state] : nxt0[m_state];
            case (m_state)
                3: begin
                    dq.delete();
                    if (m_ir >= 2 && m_ir < 2 + NC) m_cap = m_cfg[m_ir - 2];
                    else if (m_ir == 1) m_cap = 32'h1BEEF0A5;
                    else if (m_ir == 2 + NC) m_cap = DRW'(longint'(m_count) * 65536 + longint'(m_active));
                    else m_cap = '0;
                    if (m_ir == 1 || (m_ir >= 2 && m_ir <= 2 + NC))
                        for (int i = 0; i < DRW; i++) dq.push_back(m_cap[i]);
                    else
                        dq.push_back(1'b0);
                end
                4: begin
                    void'(dq.pop_front());
                    dq.push_back(tdi);
                end
                8: if (m_ir >= 2 && m_ir < 2 + NC)
                        for (int i = 0; i < DRW; i++) m_cfg[m_ir - 2][i] = dq[i];
                10: begin
                    iq.delete();
                    for (int i = 0; i < IRW; i++) iq.push_back(i == 0);
                end
                11: begin
                    void'(iq.pop_front());
                    iq.push_back(tdi);
                end
                15: begin
                    m_ir = 0;
                    for (int i = 0; i < IRW; i++) if (iq[i]) m_ir += (1 << i);
                end
                default: ;
            endcase
            if (m_ns == 0 && m_state != 0) begin
                m_ir = 1;
                m_active = 0;
            end
            if (m_rise) begin
                m_active = 1;
                if (m_count < 65535) m_count++;
            end
            m_state = m_ns;
        end
    end

    // compare DUT against the model just before every rising edge
    always @(negedge tck) begin
        #4;
        if (started) begin
            exp_tdo = 1'b0;
            if (m_state == 4 && dq.size() > 0) exp_tdo = dq[0];
            if (m_state == 11 && iq.size() > 0) exp_tdo = iq[0];
            for (int k = 0; k < NC; k++) exp_cfg[k*DRW +: DRW] = m_cfg[k];
            chk("tap_state", CW'(tap_state), CW'(m_state));
            chk("tdo", CW'(tdo), CW'(exp_tdo));
            chk("cfg_out", cfg_out, exp_cfg);
        end
    end

    task automatic step(input bit t, input bit d, output bit o);
        @(negedge tck);
        #1;
        tms = t; tdi = d; dump = dmp;
        #3;
        o = tdo;
        @(posedge tck);
    endtask

    task automatic load_ir(input logic [IRW-1:0] code);
        bit o;
        step(1, 0, o); step(1, 0, o); step(0, 0, o); step(0, 0, o);
        for (int i = 0; i < IRW; i++) step(i == IRW - 1, code[i], o);
        step(1, 0, o); step(0, 0, o);
    endtask

    task automatic scan_dr(input int n, input logic [DRW-1:0] din, output logic [DRW-1:0] dout);
        bit o;
        dout = '0;
        step(1, 0, o); step(0, 0, o); step(0, 0, o);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], o);
            dout[i] = o;
        end
        step(1, 0, o); step(0, 0, o);
    endtask

    task automatic to_tlr_rti();
        bit o;
        for (int i = 0; i < 5; i++) step(1, 0, o);
        step(0, 0, o);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DRW-1:0] v;
        bit o;
        repeat (2) @(negedge tck);
        #2;
        chk("rst_state", CW'(tap_state), CW'(0));
        chk("rst_tdo", CW'(tdo), CW'(0));
        chk("rst_cfg", cfg_out, '0);
        trst_n = 1'b1;
        started = 1'b1;
        step(0, 0, o);

        scan_dr(32, '0, v);
        #1 chk("idcode", CW'(v), CW'(32'h1BEEF0A5));

        load_ir(5'd2);
        scan_dr(32, 32'hDEADBEEF, v);
        #1 chk("cfg0_write", CW'(cfg_out[31:0]), CW'(32'hDEADBEEF));
        chk("cfg_others", CW'(cfg_out[CW-1:32]), '0);

        scan_dr(32, 32'h0, v);
        #1 chk("cfg0_read", CW'(v), CW'(32'hDEADBEEF));
        chk("cfg0_clear", CW'(cfg_out[31:0]), '0);

        load_ir(5'h1F);
        scan_dr(4, 32'b1101, v);
        #1 chk("bypass", CW'(v[3:0]), CW'(4'b1010));

        for (int p = 0; p < 3; p++) begin
            dmp = 1'b1;
            step(0, 0, o); step(0, 0, o);
            dmp = 1'b0;
            step(0, 0, o); step(0, 0, o);
        end
        load_ir(5'd6);
        scan_dr(32, '0, v);
        #1 chk("status_active", CW'(v), CW'(32'h00030001));
        to_tlr_rti();
        load_ir(5'd6);
        scan_dr(32, '0, v);
        #1 chk("status_cleared", CW'(v), CW'(32'h00030000));

        load_ir(5'd3);
        scan_dr(32, 32'hCAFE1234, v);
        #1 chk("cfg1_write", CW'(cfg_out[63:32]), CW'(32'hCAFE1234));
        load_ir(5'd3);
        step(1, 0, o); step(0, 0, o); step(0, 0, o);
        for (int i = 0; i < 10; i++) step(0, 1'($urandom), o);
        #2 trst_n = 1'b0;
        tms = 1'b1;
        #1;
        chk("midrst_state", CW'(tap_state), CW'(0));
        chk("midrst_tdo", CW'(tdo), CW'(0));
        chk("midrst_cfg", cfg_out, '0);
        @(negedge tck);
        #1 trst_n = 1'b1;
        step(0, 0, o);
        scan_dr(32, 32'h12345678, v);
        #1 chk("idcode_after_rst", CW'(v), CW'(32'h1BEEF0A5));

        for (int it = 0; it < 30; it++) begin
            load_ir(($urandom_range(0, 3) == 0) ? IRW'($urandom) : IRW'($urandom_range(0, 7)));
            scan_dr(32, $urandom, v);
            for (int i = 0; i < 40; i++) begin
                dmp = ($urandom_range(0, 3) == 0);
                step($urandom_range(0, 2) == 0, 1'($urandom), o);
            end
            dmp = 1'b0;
            to_tlr_rti();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
